// File: rtl/noise_iir_mc_pkg.sv
// Shared definitions for the multi-channel shift-coefficient noise IIR.
// Holds default sizes, the sweep/run state encoding and a generic signed
// saturation helper used by noise_iir_sat.
package noise_iir_mc_pkg;

    localparam int unsigned DSZ_DEF  = 18;
    localparam int unsigned Q_DEF    = 31;
    localparam int unsigned NCH_DEF  = 32;
    // Widest operand the saturation helper can handle.
    localparam int unsigned SAT_MAXW = 64;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } iir_state_e;

    // Clamp a sign-extended value to the signed range of an ow-bit word.
    function automatic logic signed [SAT_MAXW-1:0] sat_fn(
        input logic signed [SAT_MAXW-1:0] x,
        input int unsigned                ow
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = (SAT_MAXW'(1) << (ow - 1)) - SAT_MAXW'(1);
        lo = ~hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/noise_iir_sat.sv
// Signed saturator: narrows an IW-bit signed value to OW bits, clamping
// to the most-positive / most-negative code instead of wrapping.
//   d_i   : IW-bit signed input
//   q_c_o : OW-bit signed clamped result (combinational)
module noise_iir_sat
    import noise_iir_mc_pkg::*;
#(
    parameter int unsigned IW = 19,
    parameter int unsigned OW = 18
) (
    input  logic signed [IW-1:0] d_i,
    output logic signed [OW-1:0] q_c_o
);

    logic signed [SAT_MAXW-1:0] ext_c;
    logic signed [SAT_MAXW-1:0] sat_c;

    always_comb begin
        ext_c = {{(SAT_MAXW - IW){d_i[IW-1]}}, d_i};
        sat_c = sat_fn(ext_c, OW);
        q_c_o = OW'(sat_c);
    end

endmodule

// File: rtl/noise_iir_mc.sv
// Time-multiplexed one-pole shift-coefficient IIR (LPF/HPF per sample)
// over NCH channel accumulators, with a hardware state-clear sweep.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : input handshake
//   in_ch, in_data     : channel tag and signed sample
//   bw, hpf            : bandwidth code (0 = slowest), highpass select
//   clr_all            : request to zero every channel state
//   out_valid/out_ch/out_data : registered result, latency 1
module noise_iir_mc
    import noise_iir_mc_pkg::*;
#(
    parameter int unsigned DSZ = DSZ_DEF,
    parameter int unsigned Q   = Q_DEF,
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned CHW = $clog2(NCH),
    parameter int unsigned BWW = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CHW-1:0]        in_ch,
    input  logic signed [DSZ-1:0] in_data,
    input  logic [BWW-1:0]        bw,
    input  logic                  hpf,
    input  logic                  clr_all,
    output logic                  out_valid,
    output logic [CHW-1:0]        out_ch,
    output logic signed [DSZ-1:0] out_data
);

    localparam int unsigned ISZ = DSZ + Q;

    iir_state_e            state_q, state_d;
    logic [CHW-1:0]        idx_q, idx_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [CHW-1:0]        out_ch_q;
    logic signed [DSZ-1:0] out_data_q;

    logic signed [ISZ-1:0] acc_q [NCH];

    logic                  accept_c;
    int unsigned           coef_c;
    logic signed [ISZ-1:0] acc_rd_c;
    logic signed [ISZ-1:0] shr_c;
    logic signed [DSZ-1:0] fb_c;
    logic signed [ISZ:0]   sum_raw_c;
    logic signed [ISZ-1:0] sum_c;
    logic signed [DSZ:0]   hp_raw_c;
    logic signed [DSZ-1:0] hp_c;

    logic                  acc_we_c;
    logic [CHW-1:0]        acc_wa_c;
    logic signed [ISZ-1:0] acc_wd_c;

    assign accept_c = in_valid & in_ready_q;

    // Datapath: feedback tap, accumulator update and highpass residue.
    always_comb begin
        if (32'(bw) <= Q) begin
            coef_c = Q - 32'(bw);
        end else begin
            coef_c = 0;
        end
        acc_rd_c  = acc_q[in_ch];
        shr_c     = acc_rd_c >>> coef_c;
        sum_raw_c = (ISZ + 1)'(in_data) + (ISZ + 1)'(acc_rd_c) - (ISZ + 1)'(fb_c);
        hp_raw_c  = (DSZ + 1)'(in_data) - (DSZ + 1)'(fb_c);
    end

    noise_iir_sat #(.IW(ISZ),     .OW(DSZ)) u_sat_fb  (.d_i(shr_c),     .q_c_o(fb_c));
    noise_iir_sat #(.IW(ISZ + 1), .OW(ISZ)) u_sat_sum (.d_i(sum_raw_c), .q_c_o(sum_c));
    noise_iir_sat #(.IW(DSZ + 1), .OW(DSZ)) u_sat_hp  (.d_i(hp_raw_c),  .q_c_o(hp_c));

    // Next-state and accumulator write-port control.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_we_c = 1'b0;
        acc_wa_c = in_ch;
        acc_wd_c = sum_c;
        case (state_q)
            ST_CLEAR: begin
                acc_we_c = 1'b1;
                acc_wa_c = idx_q;
                acc_wd_c = '0;
                if (clr_all) begin
                    idx_d = '0;
                end else if (idx_q == CHW'(NCH - 1)) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CHW'(1);
                end
            end
            ST_RUN: begin
                // A sample accepted alongside clr_all is still written; the sweep clears it later.
                acc_we_c = accept_c;
                if (clr_all) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= (state_d == ST_RUN);
            out_valid_q <= accept_c;
            if (accept_c) begin
                out_ch_q   <= in_ch;
                out_data_q <= hpf ? hp_c : fb_c;
            end
        end
    end

    // Channel state array; zeroed only by the sweep, never by reset.
    always_ff @(posedge clk) begin
        if (acc_we_c) begin
            acc_q[acc_wa_c] <= acc_wd_c;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_noise_iir_mc.sv
// Directed bench for noise_iir_mc: startup sweep, delay identity, LPF/HPF
// step response, channel independence, saturation, clear and mid-sweep reset.
module tb_noise_iir_mc;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         in_ch;
    logic signed [17:0] in_data;
    logic [4:0]         bw;
    logic               hpf;
    logic               clr_all;
    logic               out_valid;
    logic [4:0]         out_ch;
    logic signed [17:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    noise_iir_mc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_data  (in_data),
        .bw       (bw),
        .hpf      (hpf),
        .clr_all  (clr_all),
        .out_valid(out_valid),
        .out_ch   (out_ch),
        .out_data (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int data, input int b, input bit h, input bit clr);
        in_valid = 1'b1;
        in_ch    = 5'(ch);
        in_data  = 18'(data);
        bw       = 5'(b);
        hpf      = h;
        clr_all  = clr;
        tick();
        in_valid = 1'b0;
        clr_all  = 1'b0;
    endtask

    task automatic send(input string tag, input int ch, input int data, input int b,
                        input bit h, input bit clr, input int exp);
        chk({tag, "_rdy"}, longint'(in_ready), 1);
        push(ch, data, b, h, clr);
        chk({tag, "_vld"}, longint'(out_valid), 1);
        chk({tag, "_ch"}, longint'(out_ch), longint'(ch));
        chk({tag, "_dat"}, longint'(out_data), longint'(exp));
    endtask

    // Count cycles until in_ready rises (bounded); outputs must stay quiet meanwhile.
    task automatic wait_ready(input string tag, input int exp_cycles, input bit zero_data);
        int n;
        bit quiet;
        n     = 0;
        quiet = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
            if (out_valid !== 1'b0) quiet = 1'b0;
            if (zero_data && out_data !== 18'sd0) quiet = 1'b0;
        end
        chk(tag, longint'(n), longint'(exp_cycles));
        chk({tag, "_quiet"}, longint'(quiet), 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_ch    = '0;
        in_data  = '0;
        bw       = '0;
        hpf      = 1'b0;
        clr_all  = 1'b0;

        // Reset and startup sweep
        repeat (3) tick();
        chk("rst_rdy", longint'(in_ready), 0);
        chk("rst_vld", longint'(out_valid), 0);
        chk("rst_ch", longint'(out_ch), 0);
        chk("rst_dat", longint'(out_data), 0);
        rst_n = 1'b1;
        wait_ready("boot", 32, 1'b1);

        // Delay identity, back-to-back on one channel
        send("id0", 3, 100, 31, 1'b0, 1'b0, 0);
        send("id1", 3, -200, 31, 1'b0, 1'b0, 100);
        send("id2", 3, 300, 31, 1'b0, 1'b0, -200);
        tick();
        chk("idle_vld", longint'(out_valid), 0);

        // LPF step, coef 1
        send("lp0", 0, 131071, 30, 1'b0, 1'b0, 0);
        send("lp1", 0, 131071, 30, 1'b0, 1'b0, 65535);
        send("lp2", 0, 131071, 30, 1'b0, 1'b0, 98303);
        send("lp3", 0, 131071, 30, 1'b0, 1'b0, 114687);
        send("lp4", 0, 131071, 30, 1'b0, 1'b0, 122879);
        repeat (40) push(0, 131071, 30, 1'b0, 1'b0);
        send("lp_conv", 0, 131071, 30, 1'b0, 1'b0, 131071);

        // HPF step, coef 1, fresh channel
        send("hp0", 4, 131071, 30, 1'b1, 1'b0, 131071);
        send("hp1", 4, 131071, 30, 1'b1, 1'b0, 65536);
        send("hp2", 4, 131071, 30, 1'b1, 1'b0, 32768);
        send("hp3", 4, 131071, 30, 1'b1, 1'b0, 16384);
        send("hp4", 4, 131071, 30, 1'b1, 1'b0, 8192);
        repeat (40) push(4, 131071, 30, 1'b1, 1'b0);
        send("hp_conv", 4, 131071, 30, 1'b1, 1'b0, 0);

        // Channel independence
        send("ci0", 1, 1000, 31, 1'b0, 1'b0, 0);
        send("ci1", 2, -1000, 31, 1'b0, 1'b0, 0);
        send("ci2", 1, 1500, 31, 1'b0, 1'b0, 1000);
        send("ci3", 2, -1500, 31, 1'b0, 1'b0, -1000);
        send("ci4", 1, 0, 31, 1'b0, 1'b0, 1500);

        // Saturation of the highpass residue
        send("sat_prime", 5, -131072, 31, 1'b1, 1'b0, -131072);
        send("sat_pos", 5, 131071, 31, 1'b1, 1'b0, 131071);
        send("sat_neg", 5, -131072, 31, 1'b1, 1'b0, -131072);

        // Clear with a coincident sample
        send("c7a", 7, 5000, 31, 1'b0, 1'b0, 0);
        send("c7b", 7, 7000, 31, 1'b0, 1'b1, 5000);
        chk("clr_drop", longint'(in_ready), 0);
        wait_ready("clr", 32, 1'b0);
        send("c7z", 7, 1234, 31, 1'b0, 1'b0, 0);
        send("c7n", 7, 50, 31, 1'b0, 1'b0, 1234);

        // Reset in the middle of a sweep
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #2;
        chk("mrst_rdy", longint'(in_ready), 0);
        chk("mrst_vld", longint'(out_valid), 0);
        chk("mrst_dat", longint'(out_data), 0);
        tick();
        rst_n = 1'b1;
        wait_ready("mrst", 32, 1'b1);
        send("post3", 3, 0, 31, 1'b0, 1'b0, 0);
        send("post7", 7, 0, 31, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
